// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared stream definitions for the pair packer and adder benches
package axis_pkg;

  localparam int c_PAIR_W = 8;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_HALF  = 1'b1;

  function automatic logic [2*c_PAIR_W-1:0] pack_pair(input logic [c_PAIR_W-1:0] hi,
                                                      input logic [c_PAIR_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/axis_pair_packer_if.sv
// rtl/axis_pair_packer_if.sv - one AXI-Stream channel with tuser
interface axis_pair_packer_if #(parameter int c_WIDTH = 8);
  logic [c_WIDTH-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic               tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-entry AXIS output register; a load always wins over a drain
module axis_out_reg #(
  parameter int c_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [c_WIDTH-1:0] ld_data,
  input  logic               ld_last,
  input  logic               ld_user,
  output logic               ready,
  axis_pair_packer_if.master m_axis
);

  // Upstream may only load when the slot is free or draining this cycle.
  assign ready = !m_axis.tvalid || m_axis.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
    end else if (load) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= ld_data;
      m_axis.tlast  <= ld_last;
      m_axis.tuser  <= ld_user;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_pair_packer.sv
// rtl/axis_pair_packer.sv - packs two consecutive beats into {second, first}; odd packets flush padded
module axis_pair_packer
  import axis_pkg::*;
#(
  parameter int c_WIDTH     = 8,
  parameter int c_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_pair_packer_if.slave      s_axis,
  axis_pair_packer_if.master     m_axis,
  output logic [c_CNT_WIDTH-1:0] pair_count
);

  logic                   state;
  logic [c_WIDTH-1:0]     low_q;
  logic [c_WIDTH-1:0]     s_data;
  logic                   s_ready;
  logic                   s_fire;
  logic                   load;
  logic [2*c_WIDTH-1:0]   ld_data;
  logic                   ld_last;
  logic                   ld_user;

  assign s_data        = s_axis.tdata;
  assign s_axis.tready = s_ready;
  assign s_fire        = s_axis.tvalid && s_ready;

  always_comb begin
    load    = s_fire && ((state == ST_HALF) || s_axis.tlast);
    ld_data = {{c_WIDTH{1'b0}}, s_data};
    ld_last = 1'b1;
    ld_user = 1'b1;
    if (state == ST_HALF) begin
      ld_data = {s_data, low_q};
      ld_last = s_axis.tlast;
      ld_user = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      low_q <= '0;
    end else if (s_fire) begin
      if (state == ST_EMPTY && !s_axis.tlast) begin
        low_q <= s_data;
        state <= ST_HALF;
      end else begin
        state <= ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_count <= '0;
    end else if (m_axis.tvalid && m_axis.tready) begin
      pair_count <= pair_count + 1'b1;
    end
  end

  axis_out_reg #(.c_WIDTH(2*c_WIDTH)) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .ld_data (ld_data),
    .ld_last (ld_last),
    .ld_user (ld_user),
    .ready   (s_ready),
    .m_axis  (m_axis)
  );

endmodule

// File: doc/axis_pair_packer.md
Name: axis_pair_packer

Overview:
- Upstream producer for the adder datapath. It gathers two consecutive c_WIDTH-bit AXI-Stream beats into one 2*c_WIDTH-bit operand-pair word.
- First beat of a pair goes to the low half; second beat goes to the high half.
- Packets are delimited by tlast. An odd-length packet is flushed with a zero-padded high half and flagged.
- Sits between narrow sample sources and any 2-operand consumer (e.g. the adder).

Parameters:
- c_WIDTH, 8, width of one input beat; output word is 2*c_WIDTH.
- c_CNT_WIDTH, 16, width of the emitted-pair statistics counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  c_WIDTH  input beat.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  2*c_WIDTH  packed pair {second, first}.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  word contains the packet's last beat.
- m_axis_tuser  out  1  odd flush: high half is zero padding.
- m_axis_tready  in  1  downstream ready.
- pair_count  out  c_CNT_WIDTH  number of words accepted downstream; wraps modulo 2^c_CNT_WIDTH.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0.
  - pair_count=0; state=EMPTY; low-half holding register=0.
- Reset mid-operation discards any partial pair and any pending output word; no flush.
- s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - This is a combinational path from m_axis_tready; it is accepted.
  - s_axis_tready never depends on s_axis_tvalid or s_axis_tdata.
  - In reset, s_axis_tready is 1.
- Input accept: s_axis_tvalid && s_axis_tready. Output accept: m_axis_tvalid && m_axis_tready.
- State EMPTY (no partial pair held), on input accept:
  - tlast=0: store tdata in the low register; go to HALF; no output.
  - tlast=1: load m_axis_tdata={c_WIDTH'b0, tdata}, m_axis_tlast=1, m_axis_tuser=1, m_axis_tvalid=1; stay in EMPTY.
- State HALF (low half held), on input accept:
  - Load m_axis_tdata={tdata, low}, m_axis_tlast=s_axis_tlast, m_axis_tuser=0, m_axis_tvalid=1; go to EMPTY.
- Output accept with no new word loaded in the same cycle: m_axis_tvalid<=0 next cycle. Data, last and user hold their values and are don't-care.
- Simultaneous output accept and a new word load: the new word wins; m_axis_tvalid stays 1; no bubble.
- While m_axis_tvalid=1 and m_axis_tready=0:
  - s_axis_tready=0 in both states. No beat is lost or overwritten.
  - m_axis_tdata, tlast and tuser are stable (AXIS rule).
- Latency: the output word is valid the cycle after the accept of the second beat (or of the odd tlast beat).
- Throughput: with m_axis_tready held at 1, one input beat per cycle is sustained and one output word is produced every 2 cycles.
- pair_count increments by 1 on every output accept. It wraps from all-ones to 0 silently.
- A packet with tlast on the second beat produces no padding word.
- Back-to-back packets need no idle cycles.

Decomposition:
- Shared package axis_pkg:
  - State encoding localparams ST_EMPTY and ST_HALF (1-bit).
  - Function pack_pair(hi, lo) returning {hi, lo}, reused by adder benches for golden data.
- One natural sub-module: axis_out_reg. It is a single-entry AXIS output register with load/accept logic, producing valid, data, last, user and the ready back-pressure term. It is reusable by the adder and future stream blocks.
- Packing FSM and the counter stay in the top module.

Test Plan (c_WIDTH=8):
- Stream 0x01,0x02,0x03,0x04 (tlast on 0x04), m_axis_tready=1 → words 0x0201 (last=0, user=0) and 0x0403 (last=1, user=0); pair_count=2; s_axis_tready constantly 1.
- Odd packet 0x11,0x22,0x33 (tlast on 0x33) → 0x2211 (last=0) then 0x0033 (last=1, user=1); the next packet starts in EMPTY.
- Single-beat packet 0xAB with tlast → 0x00AB, last=1, user=1, valid the cycle after accept.
- Back-pressure: hold m_axis_tready=0 after word 0x0201 is presented while the source offers 0x03 → s_axis_tready=0; 0x0201 is stable for 5 cycles. After ready=1, 0x0403 follows with no loss or duplication.
- Assert rst while state=HALF holding 0x5A and an output word is pending → m_axis_tvalid=0 immediately (async). After release, 0x01,0x02 yields 0x0201, not 0x015A.
- Counter wrap with c_CNT_WIDTH=2: 5 pairs → pair_count sequence 1,2,3,0,1.
